// File: rtl/load_fetch_exec.sv
// rtl/load_fetch_exec.sv - sequential lw-only executor over a shared word RAM
// Fetches from PC_START, loads data words into a 32x32 register file, and exposes it for debug.
module load_fetch_exec #(
  parameter int W        = 32,
  parameter int AW       = 4,
  parameter int PC_START = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] ram_addr,
  input  logic [W-1:0]  ram_data,
  input  logic [4:0]    reg_sel,
  output logic [W-1:0]  reg_out,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW:0]   instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_LOAD   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [AW-1:0] PC_INIT = AW'(PC_START);
  localparam logic [AW-1:0] PC_LAST = '1;
  localparam logic [6:0]    OP_LOAD = 7'b0000011;
  localparam logic [2:0]    F3_LW   = 3'b010;

  state_t          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [W-1:0]    ir_q, ir_d;
  logic [AW-1:0]   ea_q, ea_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [W-1:0]    rf_q [0:31];

  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [2:0]      funct3;
  logic [4:0]      rs1;
  logic [W-1:0]    imm;
  logic [W-1:0]    rs1_val;
  logic [W-1:0]    ea_sum;
  logic            ea_oob;
  logic            rf_we;

  assign opcode  = ir_q[6:0];
  assign rd      = ir_q[11:7];
  assign funct3  = ir_q[14:12];
  assign rs1     = ir_q[19:15];
  assign imm     = {{(W-12){ir_q[31]}}, ir_q[31:20]};
  assign rs1_val = (rs1 == 5'd0) ? '0 : rf_q[rs1];
  assign ea_sum  = rs1_val + imm;
  // Any bit above the RAM address range, including sign bits of a negative sum, is out of range.
  assign ea_oob  = |ea_sum[W-1:AW];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ea_d    = ea_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    rf_we   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          pc_d    = PC_INIT;
          err_d   = 1'b0;
          cnt_d   = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        ir_d    = ram_data;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (ir_q == '0) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (opcode == OP_LOAD && funct3 == F3_LW) begin
          ea_d = ea_sum[AW-1:0];
          if (ea_oob) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_LOAD: begin
        rf_we = (rd != 5'd0);
        cnt_d = cnt_q + 1'b1;
        // The last RAM word ends the run rather than wrapping the PC.
        if (pc_q == PC_LAST) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          pc_d    = pc_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      default: begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= PC_INIT;
      ir_q    <= '0;
      ea_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ea_q    <= ea_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      if (rf_we) begin
        rf_q[rd] <= ram_data;
      end
    end
  end

  assign ram_addr    = (state_q == S_LOAD) ? ea_q : pc_q;
  assign reg_out     = (reg_sel == 5'd0) ? '0 : rf_q[reg_sel];
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_load_fetch_exec.sv
// tb/tb_load_fetch_exec.sv - scoreboard bench for load_fetch_exec
// Runs issue expected completions into a queue; a monitor checks them when done rises.
module tb_load_fetch_exec;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  ram_addr;
  logic [31:0] ram_data;
  logic [4:0]  reg_sel;
  logic [31:0] reg_out;
  logic        busy;
  logic        done;
  logic        err;
  logic [4:0]  instr_count;

  logic [31:0] mem [16];
  int          cyc;
  int          errors;
  int          checks;

  typedef struct packed {
    logic [31:0]      exp_cyc;
    logic             err;
    logic [4:0]       cnt;
    logic [2:0]       nregs;
    logic [3:0][4:0]  idx;
    logic [3:0][31:0] val;
  } exp_t;

  exp_t q[$];

  load_fetch_exec #(.W(32), .AW(4), .PC_START(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .ram_addr    (ram_addr),
    .ram_data    (ram_data),
    .reg_sel     (reg_sel),
    .reg_out     (reg_out),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .instr_count (instr_count)
  );

  assign ram_data = mem[ram_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask

  task automatic expect_run(input int lat, input logic e, input int cnt, input int n,
                            input int i0, input int v0, input int i1, input int v1,
                            input int i2, input int v2);
    exp_t x;
    x.exp_cyc = 32'(cyc + 1 + lat);
    x.err     = e;
    x.cnt     = 5'(cnt);
    x.nregs   = 3'(n);
    x.idx     = '0;
    x.val     = '0;
    x.idx[0] = 5'(i0); x.val[0] = 32'(v0);
    x.idx[1] = 5'(i1); x.val[1] = 32'(v1);
    x.idx[2] = 5'(i2); x.val[2] = 32'(v2);
    q.push_back(x);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      check({name, "_done_timeout"}, 32'(q.size()), 32'd0);
      q.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: pops one expectation per rising edge of done.
  initial begin : monitor
    logic done_prev;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !done_prev) begin
        if (q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("done_cycle", 32'(cyc), e.exp_cyc);
          check("err", {31'd0, err}, {31'd0, e.err});
          check("instr_count", {27'd0, instr_count}, {27'd0, e.cnt});
          check("busy_at_done", {31'd0, busy}, 32'd0);
          for (int i = 0; i < int'(e.nregs); i++) begin
            reg_sel = e.idx[i];
            #1;
            check($sformatf("x%0d", e.idx[i]), reg_out, e.val[i]);
          end
        end
      end
      done_prev = done;
    end
  end

  initial begin
    errors  = 0;
    checks  = 0;
    cyc     = 0;
    rst     = 1'b0;
    start   = 1'b0;
    reg_sel = 5'd0;
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    mem[0] = 32'd33; mem[1] = 32'd58; mem[2] = 32'd47; mem[3] = 32'd159;

    #1 rst = 1'b1;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_count", {27'd0, instr_count}, 32'd0);
    check("rst_pc", {28'd0, ram_addr}, 32'd8);
    reg_sel = 5'd5;
    #1 check("rst_x5", reg_out, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Test 1: two loads then halt; a start while busy must be ignored.
    mem[8] = 32'h00102283; mem[9] = 32'h00202303; mem[10] = 32'h0;
    expect_run(8, 1'b0, 2, 2, 5, 58, 6, 47, 0, 0);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reg_sel = 5'd5;
    #1 check("t1_x5_before_E3", reg_out, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reg_sel = 5'd5;
    #1 check("t1_x5_after_E3", reg_out, 32'd58);
    check("t1_busy", {31'd0, busy}, 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("t1");

    // Test 2: base-register load with negative offset.
    mem[8] = 32'hFC82A383; mem[9] = 32'h0;
    expect_run(5, 1'b0, 1, 3, 7, 47, 5, 58, 6, 47);
    pulse_start();
    wait_idle("t2");

    // Test 3: negative effective address is out of range.
    mem[8] = 32'hFFF02383;
    expect_run(2, 1'b1, 0, 1, 7, 47, 0, 0, 0, 0);
    pulse_start();
    wait_idle("t3");

    // Test 4: lb encoding is rejected without a write.
    mem[8] = 32'h00000403;
    expect_run(2, 1'b1, 0, 1, 8, 0, 0, 0, 0, 0);
    pulse_start();
    wait_idle("t4");

    // Test 5: load into x0 counts but is discarded.
    mem[8] = 32'h00302003; mem[9] = 32'h0;
    expect_run(5, 1'b0, 1, 1, 0, 0, 0, 0, 0, 0);
    pulse_start();
    wait_idle("t5");

    // Test 6: async reset during LOAD of the second instruction.
    mem[8] = 32'h00102283; mem[9] = 32'h00202303; mem[10] = 32'h0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_done", {31'd0, done}, 32'd0);
    check("t6_err", {31'd0, err}, 32'd0);
    check("t6_count", {27'd0, instr_count}, 32'd0);
    check("t6_pc", {28'd0, ram_addr}, 32'd8);
    for (int i = 0; i < 32; i++) begin
      reg_sel = 5'(i);
      #1 check($sformatf("t6_x%0d", i), reg_out, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_idle_busy", {31'd0, busy}, 32'd0);
    check("t6_idle_done", {31'd0, done}, 32'd0);
    check("t6_no_pending", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_fetch_exec.md
Name: load_fetch_exec

Overview:
- Reader-side companion to the RAM preload block. Runs after the RAM holds data words and RV32I instruction words.
- Fetches instruction words from the shared word-addressed RAM, starting at PC_START.
- Decodes `lw` (I-type load), reads the addressed data word back from the same RAM, and writes it into an internal 32x32 register file.
- Exposes the register file to the judge/testbench through a debug read port.

Parameters:
- W, 32, data/instruction word width.
- AW, 4, RAM word-address width (depth 2**AW = 16).
- PC_START, 8, word address of the first instruction.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, one-cycle run request; sampled in IDLE or DONE only.
- ram_addr, output, AW, RAM word address; combinational from state.
- ram_data, input, W, RAM read data; combinational, valid in the same cycle as ram_addr.
- reg_sel, input, 5, debug register index.
- reg_out, output, W, combinational x[reg_sel]; reads 0 for reg_sel=0.
- busy, output, 1, high in FETCH/DECODE/LOAD.
- done, output, 1, high in DONE state.
- err, output, 1, sticky error flag; valid when done=1.
- instr_count, output, AW+1, number of retired `lw` instructions.

Behaviour:
- Reset (async, any state): state=IDLE; pc=PC_START; ir=0; ea=0; busy=0; done=0; err=0; instr_count=0; x1..x31=0.
- States are IDLE, FETCH, DECODE, LOAD, DONE.
- IDLE:
  - ram_addr=pc.
  - start=1 → FETCH.
- FETCH:
  - ram_addr=pc; ir<=ram_data.
  - → DECODE.
- DECODE: ram_addr=pc. Fields are opcode=ir[6:0], rd=ir[11:7], funct3=ir[14:12], rs1=ir[19:15], imm=sext(ir[31:20]) to W bits.
  - ir==0 (halt): → DONE, err unchanged.
  - opcode==7'b0000011 and funct3==3'b010: ea<=x[rs1]+imm (W-bit, wraps mod 2**W).
    - If the sum is ≥ 2**AW as unsigned (any upper bit set, including negative results): err<=1, → DONE.
    - Otherwise → LOAD.
  - Any other encoding: err<=1, → DONE.
- LOAD:
  - ram_addr=ea[AW-1:0].
  - If rd≠0: x[rd]<=ram_data. rd=0 writes are discarded.
  - instr_count<=instr_count+1 (also counts rd=0 loads).
  - If pc==2**AW-1: → DONE (no PC wrap). Otherwise pc<=pc+1, → FETCH.
- DONE:
  - ram_addr=pc; done=1.
  - start=1 restarts the run: pc<=PC_START, err<=0, done<=0, instr_count<=0, → FETCH. The register file is retained.
- start is ignored while busy=1.
- Latency:
  - A `lw` takes 3 cycles: FETCH, DECODE, LOAD.
  - A halt or error takes 2 cycles: FETCH, DECODE.
  - The destination register is visible on reg_out the cycle after LOAD.
- Register file:
  - x0 is hard-wired to 0.
  - Reads in DECODE use the values committed before that cycle. There is no forwarding hazard because each instruction is strictly sequential.
- The block never writes RAM. The RAM's rw/data_in are owned by the preload block.

Test Plan:
1. Basic program run.
   - Setup: RAM[0..3]=33,58,47,159. RAM[8]=`lw x5,1(x0)` (0x00102283). RAM[9]=`lw x6,2(x0)` (0x00202303). RAM[10]=0. Pulse start at edge E0.
   - Required: x5=58 after E3; x6=47 after E6; done=1 after E8; err=0; instr_count=2.
2. Base-register load.
   - Setup: after test 1, RAM[8]=`lw x7,-56(x5)` (ea=58-56=2). RAM[9]=0. Restart.
   - Required: x7=47; err=0; instr_count=1; x5 and x6 retained.
3. Out-of-range address.
   - Setup: RAM[8]=`lw x7,-1(x0)`. Pulse start.
   - Required: err=1 and done=1 two cycles after FETCH; x7 unchanged; instr_count=0.
4. Unsupported encoding.
   - Setup: RAM[8]=`lb` encoding (funct3=000). Pulse start.
   - Required: err=1; done=1; no register written.
5. rd=0 load.
   - Setup: RAM[8]=`lw x0,3(x0)`. Pulse start.
   - Required: reg_out(sel=0)=0; instr_count=1; err=0.
6. Reset mid-operation and busy behaviour.
   - Stimulus: assert rst asynchronously while in LOAD of test 1's second instruction.
   - Required: busy=done=err=0 immediately; all registers 0; pc=8.
   - start pulsed while busy=1 has no effect.
